// File: rtl/ai_neuron_top_comp.sv
// Event-driven array of leaky integrate-and-fire neurons with a leak sweep FSM
// and a saturating steering command driven by left/right spike counts.
module ai_neuron_top_comp #(
    parameter int N_NEURON   = 64,
    parameter int W_V        = 16,
    parameter int W_W        = 8,
    parameter int THRESH     = 256,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ev_valid_i,
    output logic                          ev_ready_o,
    input  logic [$clog2(N_NEURON)-1:0]   ev_idx_i,
    input  logic signed [W_W-1:0]         ev_weight_i,
    input  logic                          tick_i,
    output logic                          spike_valid_o,
    output logic [$clog2(N_NEURON)-1:0]   spike_idx_o,
    output logic signed [7:0]             motor_cmd_o,
    output logic                          busy_o
);

    localparam int W_I = $clog2(N_NEURON);
    localparam logic signed [W_V:0]   V_MAX     = {2'b00, {(W_V-1){1'b1}}};
    localparam logic signed [W_V:0]   V_MIN     = {2'b11, {(W_V-1){1'b0}}};
    localparam logic signed [W_V-1:0] THRESH_V  = W_V'(THRESH);
    localparam logic [W_I-1:0]        LAST_IDX  = W_I'(N_NEURON - 1);
    localparam logic signed [7:0]     MOTOR_MAX = 8'sd127;
    localparam logic signed [7:0]     MOTOR_MIN = -8'sd128;

    typedef enum logic {
        IDLE,
        LEAK
    } state_t;

    state_t                state_q;
    logic [W_I-1:0]        sweep_idx_q;
    logic signed [W_V-1:0] v_q [N_NEURON];
    logic                  spike_valid_q;
    logic [W_I-1:0]        spike_idx_q;
    logic signed [7:0]     motor_q;

    logic                  ev_accept;
    logic                  fire;
    logic                  left_half;
    logic signed [W_V-1:0] v_sel;
    logic signed [W_V:0]   sum_ext;
    logic signed [W_V-1:0] sum_sat;
    logic signed [W_V-1:0] v_sweep;
    logic signed [W_V-1:0] v_leak;

    assign ev_accept = ev_valid_i && (state_q == IDLE);
    assign left_half = ~ev_idx_i[W_I-1];

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        v_sel   = v_q[ev_idx_i];
        sum_ext = {v_sel[W_V-1], v_sel} + {{(W_V+1-W_W){ev_weight_i[W_W-1]}}, ev_weight_i};
        if (sum_ext > V_MAX) begin
            sum_sat = V_MAX[W_V-1:0];
        end else if (sum_ext < V_MIN) begin
            sum_sat = V_MIN[W_V-1:0];
        end else begin
            sum_sat = sum_ext[W_V-1:0];
        end
        fire    = (sum_sat >= THRESH_V);
        // Subtracting the floored shift pulls both signs toward zero without crossing it.
        v_sweep = v_q[sweep_idx_q];
        v_leak  = v_sweep - (v_sweep >>> LEAK_SHIFT);
    end

    // NOTE: the membrane array is reset with the rest of the state, so a reset mid-sweep
    // discards partial leak results; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sweep_idx_q   <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            motor_q       <= '0;
            for (int i = 0; i < N_NEURON; i++) begin
                v_q[i] <= '0;
            end
        end else begin
            spike_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ev_accept) begin
                        v_q[ev_idx_i] <= fire ? '0 : sum_sat;
                        if (fire) begin
                            spike_valid_q <= 1'b1;
                            spike_idx_q   <= ev_idx_i;
                            if (left_half && motor_q != MOTOR_MAX) begin
                                motor_q <= motor_q + 8'sd1;
                            end else if (!left_half && motor_q != MOTOR_MIN) begin
                                motor_q <= motor_q - 8'sd1;
                            end
                        end
                    end
                    // A tick coinciding with an event still lets the event land first.
                    if (tick_i) begin
                        state_q     <= LEAK;
                        sweep_idx_q <= '0;
                    end
                end
                LEAK: begin
                    v_q[sweep_idx_q] <= v_leak;
                    sweep_idx_q      <= sweep_idx_q + W_I'(1);
                    if (sweep_idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ev_ready_o    = (state_q == IDLE);
    assign busy_o        = (state_q == LEAK);
    assign spike_valid_o = spike_valid_q;
    assign spike_idx_o   = spike_idx_q;
    assign motor_cmd_o   = motor_q;

endmodule

// File: tb/tb_ai_neuron_top_comp.sv
// Directed bench for ai_neuron_top_comp: a reference model predicts spikes into a
// scoreboard queue that is drained and compared when the DUT strobes spike_valid_o.
module tb_ai_neuron_top_comp;

    localparam int N      = 64;
    localparam int W_I    = 6;
    localparam int LSHIFT = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  ev_valid_i;
    logic                  ev_ready_o;
    logic [W_I-1:0]        ev_idx_i;
    logic signed [7:0]     ev_weight_i;
    logic                  tick_i;
    logic                  spike_valid_o;
    logic [W_I-1:0]        spike_idx_o;
    logic signed [7:0]     motor_cmd_o;
    logic                  busy_o;

    ai_neuron_top_comp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ev_valid_i    (ev_valid_i),
        .ev_ready_o    (ev_ready_o),
        .ev_idx_i      (ev_idx_i),
        .ev_weight_i   (ev_weight_i),
        .tick_i        (tick_i),
        .spike_valid_o (spike_valid_o),
        .spike_idx_o   (spike_idx_o),
        .motor_cmd_o   (motor_cmd_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int motor;
    } exp_t;

    exp_t sb[$];
    int   m_v [N];
    int   m_motor;
    int   m_last_idx;
    int   m_left;
    int   m_sweep;
    int   busy_cycles;
    int   spike_count;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_v[i] = 0;
        m_motor = 0;
        m_last_idx = 0;
        m_left = 0;
        m_sweep = 0;
        sb.delete();
    endtask

    // One clock: update the model from the inputs currently driven, then compare.
    task automatic step();
        bit   exp_sv = 1'b0;
        int   s;
        exp_t e;
        if (m_left > 0) begin
            m_v[m_sweep] = m_v[m_sweep] - (m_v[m_sweep] >>> LSHIFT);
            m_sweep++;
            m_left--;
        end else begin
            if (ev_valid_i) begin
                s = m_v[ev_idx_i] + int'(ev_weight_i);
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                if (s >= 256) begin
                    m_v[ev_idx_i] = 0;
                    if (ev_idx_i < N / 2) begin
                        if (m_motor < 127) m_motor++;
                    end else begin
                        if (m_motor > -128) m_motor--;
                    end
                    e.idx = int'(ev_idx_i);
                    e.motor = m_motor;
                    sb.push_back(e);
                    exp_sv = 1'b1;
                end else begin
                    m_v[ev_idx_i] = s;
                end
            end
            if (tick_i) begin
                m_left = N;
                m_sweep = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (busy_o === 1'b1) busy_cycles++;
        if (spike_valid_o === 1'b1) spike_count++;
        check("ev_ready", ev_ready_o, m_left == 0);
        check("busy", busy_o, m_left != 0);
        check("spike_valid", spike_valid_o, exp_sv);
        if (exp_sv && sb.size() > 0) begin
            e = sb.pop_front();
            m_last_idx = e.idx;
            check("spike_motor", motor_cmd_o, e.motor);
        end
        check("spike_idx", spike_idx_o, m_last_idx);
        check("motor", motor_cmd_o, m_motor);
    endtask

    task automatic send(input int idx, input int w, input bit tk);
        ev_valid_i  = 1'b1;
        ev_idx_i    = W_I'(idx);
        ev_weight_i = 8'(w);
        tick_i      = tk;
        step();
        ev_valid_i  = 1'b0;
        tick_i      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        ev_valid_i  = 1'bx;
        ev_idx_i    = 'x;
        ev_weight_i = 'x;
        tick_i      = 1'bx;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rst_spike_valid", spike_valid_o, 0);
        check("rst_motor", motor_cmd_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_spike_idx", spike_idx_o, 0);
        ev_valid_i  = 1'b0;
        ev_idx_i    = '0;
        ev_weight_i = '0;
        tick_i      = 1'b0;
        rst_n       = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        // Reset and a long quiet period.
        apply_reset();
        check("ready_after_reset", ev_ready_o, 1);
        spike_count = 0;
        idle(1000);
        check("quiet_spikes", spike_count, 0);

        // Integrate and fire on a left-half neuron.
        send(3, 100, 1'b0);
        send(3, 100, 1'b0);
        check("v3_200", dut.v_q[3], 200);
        send(3, 100, 1'b0);
        check("t2_spike_idx", spike_idx_o, 3);
        check("t2_motor", motor_cmd_o, 1);
        check("t2_v3", dut.v_q[3], 0);
        idle(2);

        // Right-half spike pulls the command back to zero.
        send(40, 127, 1'b0);
        send(40, 127, 1'b0);
        send(40, 127, 1'b0);
        check("t3_spike_idx", spike_idx_o, 40);
        check("t3_motor", motor_cmd_o, 0);

        // Leak sweep, with a held event and an ignored second tick.
        send(5, 100, 1'b0);
        send(5, 100, 1'b0);
        send(6, -100, 1'b0);
        tick_i = 1'b1;
        busy_cycles = 0;
        step();
        tick_i = 1'b0;
        ev_valid_i  = 1'b1;
        ev_idx_i    = 6'd7;
        ev_weight_i = 8'sd10;
        idle(10);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        while (m_left > 0) step();
        step();
        ev_valid_i = 1'b0;
        check("t4_busy_cycles", busy_cycles, 64);
        check("t4_v5", dut.v_q[5], 188);
        check("t4_v6", dut.v_q[6], -93);
        check("t4_v7", dut.v_q[7], 10);
        busy_cycles = 0;
        idle(5);
        check("t4_no_requeue", busy_cycles, 0);

        // Tick and event in the same cycle.
        send(1, 50, 1'b1);
        check("t5_v1", dut.v_q[1], 50);
        check("t5_leak_next", busy_o, 1);
        while (m_left > 0) step();
        check("t5_v1_leaked", dut.v_q[1], 47);

        // Drive the command into positive saturation.
        for (int k = 0; k < 130; k++) begin
            send(k % 32, 127, 1'b0);
            send(k % 32, 127, 1'b0);
            send(k % 32, 127, 1'b0);
        end
        check("t6_motor_clamp", motor_cmd_o, 127);
        send(2, 127, 1'b0);
        send(2, 127, 1'b0);
        send(2, 127, 1'b0);
        check("t6_motor_hold", motor_cmd_o, 127);

        // Asynchronous reset in the middle of a sweep.
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        idle(20);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_motor", motor_cmd_o, 0);
        check("t6_rst_spike", spike_valid_o, 0);
        check("t6_rst_v5", dut.v_q[5], 0);
        apply_reset();
        check("t6_ready", ev_ready_o, 1);
        idle(70);
        send(9, 127, 1'b0);
        check("t6_v9_fresh", dut.v_q[9], 127);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
